des_round_sequencer: RTL

Block-level initiator for the iterative DES core. It accepts one 64-bit block with its key and direction on a valid/ready input port, then steps the core's `roundSel` through all sixteen rounds. It captures `desOut` and presents the result on a valid/ready output port. It sits between the system datapath and the `des` instance, replacing the free-running external round counter that the top level currently needs.

---
 rtl/des_round_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/des_round_sequencer.sv
// Round sequencer for the iterative DES core: accepts a block, sweeps roundSel 0..15, captures the result.
// Optional one-entry input prefetch buffer is enabled by defining DES_SEQ_PREFETCH_EN.
module des_round_sequencer #(
    parameter int unsigned CORE_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [55:0]      in_key,
    input  logic             in_decrypt,
    output logic [3:0]       core_roundSel,
    output logic             core_decrypt,
    output logic [55:0]      core_key,
    output logic [63:0]      core_desIn,
    input  logic [63:0]      core_desOut,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEY_W  = 56;
    localparam int unsigned RND_W  = 4;
    localparam int unsigned LAT_W  = 2;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(15);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [KEY_W-1:0]   wkey_q, wkey_d;
    logic               wdec_q, wdec_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_c;
    logic               out_hs_c;

`ifdef DES_SEQ_PREFETCH_EN
    logic               buf_vld_q, buf_vld_d;
    logic [DATA_W-1:0]  buf_data_q, buf_data_d;
    logic [KEY_W-1:0]   buf_key_q, buf_key_d;
    logic               buf_dec_q, buf_dec_d;

    assign in_ready = !rst && ((state_q == S_IDLE) || !buf_vld_q);
`else
    assign in_ready = !rst && (state_q == S_IDLE);
`endif

    assign accept_c = in_valid && in_ready;
    assign out_hs_c = out_valid_q && out_ready;

    // Next-state and datapath; roundSel register is held at 0 outside RUN
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        lat_d       = lat_q;
        wdata_d     = wdata_q;
        wkey_d      = wkey_q;
        wdec_d      = wdec_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
`ifdef DES_SEQ_PREFETCH_EN
        buf_vld_d   = buf_vld_q;
        buf_data_d  = buf_data_q;
        buf_key_d   = buf_key_q;
        buf_dec_d   = buf_dec_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    wdata_d = in_data;
                    wkey_d  = in_key;
                    wdec_d  = in_decrypt;
                    rnd_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (rnd_q == LAST_RND) begin
                    rnd_d   = '0;
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    out_data_d  = core_desOut;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_HOLD: begin
                if (out_hs_c) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
`ifdef DES_SEQ_PREFETCH_EN
                    // Chain straight into the next block: buffered one first, else a same-edge offer
                    if (buf_vld_q) begin
                        wdata_d   = buf_data_q;
                        wkey_d    = buf_key_q;
                        wdec_d    = buf_dec_q;
                        buf_vld_d = 1'b0;
                        rnd_d     = '0;
                        state_d   = S_RUN;
                        busy_d    = 1'b1;
                    end else if (accept_c) begin
                        wdata_d = in_data;
                        wkey_d  = in_key;
                        wdec_d  = in_decrypt;
                        rnd_d   = '0;
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DES_SEQ_PREFETCH_EN
        if (accept_c && (state_q != S_IDLE) && !((state_q == S_HOLD) && out_hs_c)) begin
            buf_vld_d  = 1'b1;
            buf_data_d = in_data;
            buf_key_d  = in_key;
            buf_dec_d  = in_decrypt;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rnd_q       <= '0;
            lat_q       <= '0;
            wdata_q     <= '0;
            wkey_q      <= '0;
            wdec_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef DES_SEQ_PREFETCH_EN
            buf_vld_q   <= 1'b0;
            buf_data_q  <= '0;
            buf_key_q   <= '0;
            buf_dec_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            lat_q       <= lat_d;
            wdata_q     <= wdata_d;
            wkey_q      <= wkey_d;
            wdec_q      <= wdec_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
`ifdef DES_SEQ_PREFETCH_EN
            buf_vld_q   <= buf_vld_d;
            buf_data_q  <= buf_data_d;
            buf_key_q   <= buf_key_d;
            buf_dec_q   <= buf_dec_d;
`endif
        end
    end

    assign core_roundSel = rnd_q;
    assign core_desIn    = wdata_q;
    assign core_key      = wkey_q;
    assign core_decrypt  = wdec_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign blk_count     = cnt_q;

endmodule
